// File: rtl/midi_tx.sv
// MIDI 1.0 note-event transmitter: one event per valid/ready handshake becomes
// a Note On / Note Off message on an 8N1 UART line, with optional running status.
module midi_tx #(
   parameter int unsigned CLKS_PER_BIT         = 512,
   parameter bit          NOTE_OFF_AS_ZERO_VEL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic       ev_note_on,
   input  logic [3:0] ev_channel,
   input  logic [6:0] ev_note,
   input  logic [6:0] ev_velocity,
   input  logic       running_status_en,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   // Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready;
   // ev_ready depends only on the state register (and reset), never on ev_valid.
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [7:0]    status_q, status_d;
   logic [6:0]    note_q, note_d;
   logic [6:0]    vel_q, vel_d;
   logic [7:0]    last_status_q, last_status_d;
   logic          last_status_valid_q, last_status_valid_d;
   logic          tx_q, tx_d;

   logic [7:0]    ev_status;
   logic [6:0]    ev_vel;
   logic          skip_status;
   logic          baud_end;
   logic [7:0]    cur_byte;

   assign ev_ready = (state_q == IDLE) && !reset;
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;

   always_comb begin
      ev_status   = {3'b100, (ev_note_on | NOTE_OFF_AS_ZERO_VEL), ev_channel};
      ev_vel      = (!ev_note_on && NOTE_OFF_AS_ZERO_VEL) ? 7'd0 : ev_velocity;
      skip_status = running_status_en && last_status_valid_q && (ev_status == last_status_q);
      baud_end    = (baud_q == BAUD_LAST);
      case (byte_q)
         2'd0:    cur_byte = status_q;
         2'd1:    cur_byte = {1'b0, note_q};
         default: cur_byte = {1'b0, vel_q};
      endcase
   end

   // tx_d always carries the line level of the bit that state_d will be in.
   always_comb begin
      state_d             = state_q;
      baud_d              = baud_q;
      bit_d               = bit_q;
      byte_d              = byte_q;
      status_d            = status_q;
      note_d              = note_q;
      vel_d               = vel_q;
      last_status_d       = last_status_q;
      last_status_valid_d = last_status_valid_q;
      tx_d                = tx_q;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = 3'd0;
            tx_d   = 1'b1;
            if (ev_valid) begin
               state_d  = START;
               tx_d     = 1'b0;
               status_d = ev_status;
               note_d   = ev_note;
               vel_d    = ev_vel;
               byte_d   = skip_status ? 2'd1 : 2'd0;
               // Committed now; a reset before the status byte completes clears it anyway.
               if (!skip_status) begin
                  last_status_d       = ev_status;
                  last_status_valid_d = 1'b1;
               end
            end
         end
         START: begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
            if (baud_end) begin
               state_d = DATA;
               bit_d   = 3'd0;
               tx_d    = cur_byte[0];
            end
         end
         DATA: begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
            if (baud_end) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  bit_d   = 3'd0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end
         end
         default: begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
            if (baud_end) begin
               if (byte_q < 2'd2) begin
                  state_d = START;
                  byte_d  = byte_q + 2'd1;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  byte_d  = 2'd0;
                  tx_d    = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= IDLE;
         baud_q              <= '0;
         bit_q               <= 3'd0;
         byte_q              <= 2'd0;
         status_q            <= 8'd0;
         note_q              <= 7'd0;
         vel_q               <= 7'd0;
         last_status_q       <= 8'd0;
         last_status_valid_q <= 1'b0;
         tx_q                <= 1'b1;
      end else begin
         state_q             <= state_d;
         baud_q              <= baud_d;
         bit_q               <= bit_d;
         byte_q              <= byte_d;
         status_q            <= status_d;
         note_q              <= note_d;
         vel_q               <= vel_d;
         last_status_q       <= last_status_d;
         last_status_valid_q <= last_status_valid_d;
         tx_q                <= tx_d;
      end
   end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (note-off as 0x8n / as zero-velocity 0x9n),
// a UART monitor feeding a byte scoreboard, and a message-level reference model.
module tb_midi_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       sel;
   logic       mon_en;
   logic       ev_valid;
   logic       ev_note_on;
   logic [3:0] ev_channel;
   logic [6:0] ev_note;
   logic [6:0] ev_velocity;
   logic       rs_en;
   logic       rdy0, tx0, busy0, rdyz, txz, busyz;
   logic       rdy_s, tx_s, busy_s;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_ls[2];
   bit         model_lsv[2];

   always #5 clk = ~clk;

   assign rdy_s  = sel ? rdyz  : rdy0;
   assign tx_s   = sel ? txz   : tx0;
   assign busy_s = sel ? busyz : busy0;

   midi_tx #(.CLKS_PER_BIT(CPB), .NOTE_OFF_AS_ZERO_VEL(1'b0)) dut (
      .clk(clk), .reset(reset), .ev_valid(ev_valid && !sel), .ev_ready(rdy0),
      .ev_note_on(ev_note_on), .ev_channel(ev_channel), .ev_note(ev_note),
      .ev_velocity(ev_velocity), .running_status_en(rs_en), .tx(tx0), .busy(busy0)
   );

   midi_tx #(.CLKS_PER_BIT(CPB), .NOTE_OFF_AS_ZERO_VEL(1'b1)) dut_z (
      .clk(clk), .reset(reset), .ev_valid(ev_valid && sel), .ev_ready(rdyz),
      .ev_note_on(ev_note_on), .ev_channel(ev_channel), .ev_note(ev_note),
      .ev_velocity(ev_velocity), .running_status_en(rs_en), .tx(txz), .busy(busyz)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Message-level model: bytes a Note On/Off event must produce on the selected instance.
   task automatic model_event(input bit on, input int ch, input int note, input int vel,
                              input bit rs, output int nbytes);
      int st;
      int v;
      int z;
      z  = sel ? 1 : 0;
      st = (on || z == 1) ? (8'h90 + ch) : (8'h80 + ch);
      v  = (!on && z == 1) ? 0 : vel;
      if (rs && model_lsv[z] && model_ls[z] == st[7:0]) begin
         nbytes = 2;
      end else begin
         exp_q.push_back(st[7:0]);
         model_ls[z]  = st[7:0];
         model_lsv[z] = 1'b1;
         nbytes = 3;
      end
      exp_q.push_back(note[7:0]);
      exp_q.push_back(v[7:0]);
   endtask

   // Called just after a falling edge; returns just after the falling edge where ev_ready is back.
   task automatic send(input bit on, input int ch, input int note, input int vel,
                       input bit rs, input bit hold, output int waited);
      int nb;
      int cnt;
      ev_note_on  = on;
      ev_channel  = ch[3:0];
      ev_note     = note[6:0];
      ev_velocity = vel[6:0];
      rs_en       = rs;
      ev_valid    = 1'b1;
      waited = 0;
      while (!rdy_s && waited < 50 * CPB) begin
         @(negedge clk);
         waited++;
      end
      if (!rdy_s) begin
         chk("accept_timeout", 32'd0, 32'd1);
         ev_valid = 1'b0;
         return;
      end
      model_event(on, ch, note, vel, rs, nb);
      @(negedge clk);
      if (!hold) ev_valid = 1'b0;
      ev_note_on  = 1'($urandom);
      ev_channel  = 4'($urandom);
      ev_note     = 7'($urandom);
      ev_velocity = 7'($urandom);
      rs_en       = 1'($urandom);
      chk("start_latency_tx", {31'd0, tx_s}, 32'd0);
      chk("busy_after_accept", {31'd0, busy_s}, 32'd1);
      cnt = 0;
      while (!rdy_s && cnt < 40 * CPB) begin
         cnt++;
         @(negedge clk);
      end
      chk("ready_low_cycles", cnt, nb * 10 * CPB);
   endtask

   // UART monitor: start bit detected on its first cycle, then mid-bit sampling.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && tx_s === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            chk("start_bit_mid", {31'd0, tx_s}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx_s;
            end
            repeat (CPB) @(negedge clk);
            chk("stop_bit_mid", {31'd0, tx_s}, 32'd1);
            if (exp_q.size() == 0) chk("rx_unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
            else chk("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int w;
      int bad;
      reset = 1'b1; sel = 1'b0; mon_en = 1'b1; ev_valid = 1'b0;
      ev_note_on = 1'b0; ev_channel = 4'd0; ev_note = 7'd0; ev_velocity = 7'd0; rs_en = 1'b0;
      model_lsv[0] = 1'b0; model_lsv[1] = 1'b0; model_ls[0] = 8'd0; model_ls[1] = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset_tx", {31'd0, tx0}, 32'd1);
      chk("reset_busy", {31'd0, busy0}, 32'd0);
      chk("reset_ready", {31'd0, rdy0}, 32'd0);
      chk("reset_ready_z", {31'd0, rdyz}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1) bad++;
         @(negedge clk);
      end
      chk("idle_bad_cycles", bad, 0);

      // Directed messages from the plan.
      send(1'b1, 2, 60, 100, 1'b0, 1'b0, w);
      send(1'b1, 0, 64, 127, 1'b1, 1'b0, w);
      send(1'b1, 0, 67, 127, 1'b1, 1'b0, w);
      send(1'b1, 1, 67, 127, 1'b1, 1'b0, w);
      send(1'b0, 5, 60, 64, 1'b0, 1'b0, w);
      send(1'b1, 7, 1, 2, 1'b1, 1'b1, w);
      send(1'b1, 7, 3, 4, 1'b1, 1'b1, w);
      chk("b2b_wait", w, 0);
      send(1'b0, 7, 5, 6, 1'b1, 1'b0, w);
      chk("b2b_wait2", w, 0);

      sel = 1'b1;
      send(1'b1, 5, 10, 20, 1'b0, 1'b0, w);
      send(1'b0, 5, 60, 64, 1'b1, 1'b0, w);
      send(1'b0, 5, 60, 64, 1'b1, 1'b0, w);

      // Randomized events on both instances; few channels so running status hits often.
      for (int k = 0; k < 40; k++) begin
         if (k == 25) sel = 1'b0;
         send(1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 127),
              $urandom_range(0, 127), 1'($urandom_range(0, 1)),
              (k != 24 && k != 39) ? 1'($urandom_range(0, 1)) : 1'b0, w);
      end

      // Reset during data bits of byte 2 truncates the message.
      sel = 1'b0; mon_en = 1'b0;
      ev_note_on = 1'b1; ev_channel = 4'd3; ev_note = 7'd10; ev_velocity = 7'd20;
      rs_en = 1'b1; ev_valid = 1'b1;
      w = 0;
      while (!rdy0 && w < 50 * CPB) begin @(negedge clk); w++; end
      @(negedge clk);
      ev_valid = 1'b0;
      repeat (23 * CPB - 1) @(negedge clk);
      chk("pre_reset_busy", {31'd0, busy0}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_mid_tx", {31'd0, tx0}, 32'd1);
      chk("reset_mid_busy", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_lsv[0] = 1'b0; model_lsv[1] = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, rdy0}, 32'd1);
      mon_en = 1'b1;
      @(negedge clk);
      send(1'b1, 3, 10, 20, 1'b1, 1'b0, w);

      w = 0;
      while (exp_q.size() != 0 && w < 100 * CPB) begin @(negedge clk); w++; end
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Serialises note events into MIDI 1.0 channel-voice messages on a UART line: 8N1, 31250 baud, LSB first, idle high.
- It is the transmit counterpart of the MIDI receive path in midi_player. It lets a board forward or echo notes, for example from switches or quadrature dials, to an external synth or to a second tiny-synth board.
- It accepts one event per valid/ready handshake and emits Note On / Note Off messages, with optional running status.

Parameters:
- CLKS_PER_BIT, 512, clk cycles per UART bit (16 MHz / 31250); must be >= 2.
- NOTE_OFF_AS_ZERO_VEL, 0, if 1 a note-off is sent as Note On (0x9n) with velocity 0x00 instead of 0x8n.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ev_valid  input  1  event offered
- ev_ready  output  1  block can accept an event this cycle
- ev_note_on  input  1  1 = note on, 0 = note off
- ev_channel  input  4  MIDI channel 0..15
- ev_note  input  7  note number
- ev_velocity  input  7  velocity; for note-off this is the release velocity, ignored when NOTE_OFF_AS_ZERO_VEL=1
- running_status_en  input  1  allow omission of a repeated status byte
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a message is being shifted out

Behaviour:
- Single clock domain. reset has priority over all other logic.
- During reset: tx=1, busy=0, ev_ready=0, state=IDLE, bit and baud counters = 0, last_status_valid=0.
- Reset mid-frame truncates the frame: tx is 1 on the first cycle after reset asserts and the message is dropped.
- ev_ready = (state==IDLE) && !reset. It is combinational from state.
- An event is accepted on a cycle with ev_valid && ev_ready. Fields are captured in that cycle; later input changes have no effect.
- Status byte:
  - note-on: 0x90|ch
  - note-off with NOTE_OFF_AS_ZERO_VEL=0: 0x80|ch
  - note-off with NOTE_OFF_AS_ZERO_VEL=1: 0x90|ch, velocity forced to 0
- Status is skipped when running_status_en=1, last_status_valid=1 and status==last_status. The message is then 2 bytes (note, velocity); otherwise it is 3 bytes.
- running_status_en is sampled at acceptance.
- After every status byte actually sent: last_status <= status, last_status_valid <= 1.
- States:
  - IDLE: accept an event, then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then go to START if more bytes remain in the message, else IDLE.
- Latency: tx falls on the first clock after the acceptance cycle.
- Bytes within a message are back-to-back with no gap beyond the stop bit.
- Message duration: 30*CLKS_PER_BIT cycles for 3 bytes, 20*CLKS_PER_BIT for 2 bytes. ev_ready rises in the cycle after the last stop-bit cycle.
- busy = (state != IDLE).
- tx is driven from a register, so it is glitch-free.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps at bit boundaries. Bit index runs 0..7 and wraps per byte. Byte index runs 0..2.
- ev_valid held high while ev_ready=0 is legal; the event is taken when the block returns to IDLE.
- ev_valid is not required to be held until acceptance. An event dropped before acceptance is simply not sent.
- Data bits are taken from the captured byte, so there is no width truncation beyond 7-bit fields. Bit 7 of data bytes is always 0.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset released, no events -> tx=1, busy=0, ev_ready=1 indefinitely.
- Note on, ch 2, note 60, vel 100, running_status_en=0 -> bytes 0x92, 0x3C, 0x64 decoded by a bench UART monitor. Start bit begins 1 cycle after accept. ev_ready low for exactly 120 cycles.
- Two note-ons on ch 0 (notes 64 then 67, vel 127), running_status_en=1 -> first message 0x90 0x40 0x7F, second message 0x43 0x7F only (80 cycles). A third event on ch 1 sends 0x91 again.
- Note-off ch 5, note 60, vel 64: NOTE_OFF_AS_ZERO_VEL=0 -> 0x85 0x3C 0x40; NOTE_OFF_AS_ZERO_VEL=1 with last status 0x95 and running_status_en=1 -> 0x3C 0x00.
- ev_valid held high with back-to-back events -> each accepted the cycle after the previous message ends. Inputs changed mid-message do not alter the bytes in flight.
- Reset asserted during the data bits of byte 2 -> tx=1 the next cycle, ev_ready=1 after release. The next event re-sends its status byte even with running_status_en=1. With CLKS_PER_BIT=512, bit period measured = 32 µs at 16 MHz.
